// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with a single valid/ready pipeline register
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      alu_op,
    output logic            alu_sub,
    output logic            alu_sra,
    output logic [1:0]      src1_sel,
    output logic            src2_imm,
    output logic            rd_we,
    output logic [2:0]      out_kind,
    output logic [2:0]      out_funct3,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] KIND_ALU    = 3'b000;
    localparam logic [2:0] KIND_LOAD   = 3'b001;
    localparam logic [2:0] KIND_STORE  = 3'b010;
    localparam logic [2:0] KIND_BRANCH = 3'b011;
    localparam logic [2:0] KIND_JAL    = 3'b100;
    localparam logic [2:0] KIND_JALR   = 3'b101;

    localparam logic [1:0] SRC1_RS1  = 2'b00;
    localparam logic [1:0] SRC1_PC   = 2'b01;
    localparam logic [1:0] SRC1_ZERO = 2'b10;

    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [2:0]      alu_op;
        logic            alu_sub;
        logic            alu_sra;
        logic [1:0]      src1_sel;
        logic            src2_imm;
        logic            rd_we;
        logic [2:0]      kind;
        logic [2:0]      funct3;
        logic            illegal;
    } dec_t;

    dec_t dec;
    dec_t dec_d;
    dec_t dec_q;
    logic valid_d;
    logic valid_q;
    logic load;
    logic writes_rd;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign imm_i = XLEN'($signed(in_instr[31:20]));
    assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0}));

    // Combinational decode of the offered instruction into the register payload
    always_comb begin
        writes_rd    = 1'b0;
        dec          = '0;
        dec.pc       = in_pc;
        dec.rd       = in_instr[11:7];
        dec.rs1      = in_instr[19:15];
        dec.rs2      = in_instr[24:20];
        dec.funct3   = funct3;
        dec.kind     = KIND_ALU;
        dec.src1_sel = SRC1_RS1;

        case (opcode)
            OPC_OP: begin
                dec.alu_op  = funct3;
                dec.alu_sub = (funct3 == 3'b000) & in_instr[30];
                dec.alu_sra = (funct3 == 3'b101) & in_instr[30];
                writes_rd   = 1'b1;
                if (!((funct7 == 7'b0) ||
                      ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
                    dec.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.alu_op   = funct3;
                dec.imm      = imm_i;
                dec.src2_imm = 1'b1;
                dec.alu_sra  = (funct3 == 3'b101) & in_instr[30];
                writes_rd    = 1'b1;
                if ((funct3 == 3'b001) && (funct7 != 7'b0))
                    dec.illegal = 1'b1;
                if ((funct3 == 3'b101) && (funct7 != 7'b0) && (funct7 != FUNCT7_ALT))
                    dec.illegal = 1'b1;
            end
            OPC_LUI: begin
                dec.src1_sel = SRC1_ZERO;
                dec.imm      = imm_u;
                dec.src2_imm = 1'b1;
                writes_rd    = 1'b1;
            end
            OPC_AUIPC: begin
                dec.src1_sel = SRC1_PC;
                dec.imm      = imm_u;
                dec.src2_imm = 1'b1;
                writes_rd    = 1'b1;
            end
            OPC_JAL: begin
                dec.src1_sel = SRC1_PC;
                dec.imm      = imm_j;
                dec.src2_imm = 1'b1;
                dec.kind     = KIND_JAL;
                writes_rd    = 1'b1;
            end
            OPC_JALR: begin
                dec.imm      = imm_i;
                dec.src2_imm = 1'b1;
                dec.kind     = KIND_JALR;
                writes_rd    = 1'b1;
                if (funct3 != 3'b000)
                    dec.illegal = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm  = imm_b;
                dec.kind = KIND_BRANCH;
                // Equality compares subtract; signed/unsigned compares use slt/sltu
                case (funct3[2:1])
                    2'b00:   begin dec.alu_op = 3'b000; dec.alu_sub = 1'b1; end
                    2'b10:   dec.alu_op = 3'b010;
                    2'b11:   dec.alu_op = 3'b011;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.imm      = imm_i;
                dec.src2_imm = 1'b1;
                dec.kind     = KIND_LOAD;
                writes_rd    = 1'b1;
                if ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))
                    dec.illegal = 1'b1;
            end
            OPC_STORE: begin
                dec.imm      = imm_s;
                dec.src2_imm = 1'b1;
                dec.kind     = KIND_STORE;
                if ((funct3 == 3'b011) || funct3[2])
                    dec.illegal = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        // Compressed-space encodings never reach this decoder legitimately
        if (in_instr[1:0] != 2'b11)
            dec.illegal = 1'b1;

        dec.rd_we = writes_rd & (dec.rd != 5'd0);

        // Illegal instructions travel down the pipe but must have no side effects
        if (dec.illegal) begin
            dec.rd_we   = 1'b0;
            dec.alu_sub = 1'b0;
            dec.alu_sra = 1'b0;
            dec.kind    = KIND_ALU;
        end
    end

    assign in_ready = !valid_q | out_ready;
    assign load     = in_valid & in_ready & !flush;

    // Next-state of the pipeline register: flush wins, then load, then drain
    always_comb begin
        dec_d   = dec_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            dec_d   = dec;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Pipeline register; payload only changes on a load so stalls are bit-stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = dec_q.pc;
    assign out_rd      = dec_q.rd;
    assign out_rs1     = dec_q.rs1;
    assign out_rs2     = dec_q.rs2;
    assign out_imm     = dec_q.imm;
    assign alu_op      = dec_q.alu_op;
    assign alu_sub     = dec_q.alu_sub;
    assign alu_sra     = dec_q.alu_sra;
    assign src1_sel    = dec_q.src1_sel;
    assign src2_imm    = dec_q.src2_imm;
    assign rd_we       = dec_q.rd_we;
    assign out_kind    = dec_q.kind;
    assign out_funct3  = dec_q.funct3;
    assign out_illegal = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic [2:0]  alu_op;
    logic        alu_sub;
    logic        alu_sra;
    logic [1:0]  src1_sel;
    logic        src2_imm;
    logic        rd_we;
    logic [2:0]  out_kind;
    logic [2:0]  out_funct3;
    logic        out_illegal;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_imm    (out_imm),
        .alu_op     (alu_op),
        .alu_sub    (alu_sub),
        .alu_sra    (alu_sra),
        .src1_sel   (src1_sel),
        .src2_imm   (src2_imm),
        .rd_we      (rd_we),
        .out_kind   (out_kind),
        .out_funct3 (out_funct3),
        .out_illegal(out_illegal)
    );

    logic [94:0] obs;
    assign obs = {out_pc, out_rd, out_rs1, out_rs2, out_imm, alu_op, alu_sub, alu_sra,
                  src1_sel, src2_imm, rd_we, out_kind, out_funct3, out_illegal};

    typedef struct packed {
        logic [94:0] e;
        logic [13:0] c;
    } sb_t;

    sb_t         sb[$];
    sb_t         pend;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [94:0] snap;

    localparam logic [13:0] C_ALL   = 14'h3FFF;
    localparam logic [13:0] C_NOSRA = 14'h3FBF;
    localparam logic [13:0] C_BR    = 14'h3F9F;
    localparam logic [13:0] C_UJ    = 14'h3FAF;
    localparam logic [13:0] C_ST    = 14'h3F8F;
    localparam logic [13:0] C_ILL   = 14'h3CCF;

    function automatic logic [94:0] mk_mask(input logic [13:0] c);
        return {{32{c[13]}}, {5{c[12]}}, {5{c[11]}}, {5{c[10]}}, {32{c[9]}}, {3{c[8]}},
                c[7], c[6], {2{c[5]}}, c[4], c[3], {3{c[2]}}, {3{c[1]}}, c[0]};
    endfunction

    function automatic logic [94:0] ev(input logic [31:0] pc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [31:0] imm, input logic [2:0] op,
                                       input logic sub, input logic sra, input logic [1:0] s1,
                                       input logic s2i, input logic we, input logic [2:0] kind,
                                       input logic [2:0] f3, input logic ill);
        return {pc, rd, rs1, rs2, imm, op, sub, sra, s1, s2i, we, kind, f3, ill};
    endfunction

    task automatic chk(input string tag, input logic [94:0] o, input logic [94:0] e,
                       input logic [94:0] m);
        n_checks++;
        assert ((o & m) === (e & m)) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o & m, e & m);
        end
    endtask

    task automatic chk1(input string tag, input logic o, input logic e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    // One clock: check in_ready, update the scoreboard, then check the register
    task automatic tick(input string tag);
        logic exp_rdy;
        logic acc;
        logic con;
        #1;
        exp_rdy = (sb.size() == 0) | out_ready;
        chk1({tag, "/in_ready"}, in_ready, exp_rdy);
        acc = in_valid & exp_rdy & ~flush;
        con = (sb.size() != 0) & out_ready;
        @(posedge clk);
        #1;
        if (flush) begin
            sb.delete();
        end else begin
            if (con) void'(sb.pop_front());
            if (acc) sb.push_back(pend);
        end
        chk1({tag, "/out_valid"}, out_valid, sb.size() != 0);
        if (sb.size() != 0) chk({tag, "/fields"}, obs, sb[0].e, mk_mask(sb[0].c));
    endtask

    task automatic send(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [94:0] e, input logic [13:0] c);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        flush     = 1'b0;
        out_ready = 1'b1;
        pend.e    = e;
        pend.c    = c;
        tick(tag);
    endtask

    task automatic idle(input string tag);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        pend      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset/out_valid", out_valid, 1'b0);
        chk1("reset/in_ready", in_ready, 1'b1);
        chk("reset/outputs", obs, 95'd0, mk_mask(C_ALL));
        rst_n = 1'b1;

        // Back-to-back decode stream covering every format
        send("add",   32'h002081B3, 32'h100,
             ev(32'h100, 5'd3, 5'd1, 5'd2, 32'h0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0), C_NOSRA);
        send("sub",   32'h402081B3, 32'h104,
             ev(32'h104, 5'd3, 5'd1, 5'd2, 32'h0, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0), C_NOSRA);
        send("srai",  32'h40335293, 32'h108,
             ev(32'h108, 5'd5, 5'd6, 5'd3, 32'h403, 3'b101, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 3'b000, 3'b101, 1'b0), C_ALL);
        send("blt",   32'hFE20CEE3, 32'h10C,
             ev(32'h10C, 5'd29, 5'd1, 5'd2, 32'hFFFFFFFC, 3'b010, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b011, 3'b100, 1'b0), C_BR);
        send("lui",   32'h12345037, 32'h110,
             ev(32'h110, 5'd0, 5'd8, 5'd3, 32'h12345000, 3'b000, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 3'b000, 3'b101, 1'b0), C_UJ);
        send("jal",   32'h008000EF, 32'h114,
             ev(32'h114, 5'd1, 5'd0, 5'd8, 32'h8, 3'b000, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 3'b100, 3'b000, 1'b0), C_UJ);
        send("lw",    32'hFF812383, 32'h118,
             ev(32'h118, 5'd7, 5'd2, 5'd24, 32'hFFFFFFF8, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 3'b001, 3'b010, 1'b0), C_NOSRA);
        send("sw",    32'h0050A623, 32'h11C,
             ev(32'h11C, 5'd12, 5'd1, 5'd5, 32'hC, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 3'b010, 3'b010, 1'b0), C_ST);
        send("jalr",  32'h00008067, 32'h120,
             ev(32'h120, 5'd0, 5'd1, 5'd0, 32'h0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 3'b101, 3'b000, 1'b0), C_UJ);
        send("auipc", 32'h00001217, 32'h124,
             ev(32'h124, 5'd4, 5'd0, 5'd0, 32'h1000, 3'b000, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 3'b000, 3'b001, 1'b0), C_UJ);

        // Illegal encodings still flow down with no side effects
        send("ill_zero",   32'h00000000, 32'h128,
             ev(32'h128, 5'd0, 5'd0, 5'd0, 32'h0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1), C_ILL);
        send("ill_mul",    32'h022081B3, 32'h12C,
             ev(32'h12C, 5'd3, 5'd1, 5'd2, 32'h0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1), C_ILL);
        send("ill_br010",  32'h0020A063, 32'h130,
             ev(32'h130, 5'd0, 5'd1, 5'd2, 32'h0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1), C_ILL);
        send("ill_rvc",    32'h002081B1, 32'h134,
             ev(32'h134, 5'd3, 5'd1, 5'd2, 32'h0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1), C_ILL);
        send("ill_slli",   32'h40109093, 32'h138,
             ev(32'h138, 5'd1, 5'd1, 5'd1, 32'h0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1), C_ILL);
        idle("drain0");

        // Backpressure: three stalled cycles, then release
        send("bp_first", 32'h002081B3, 32'h200,
             ev(32'h200, 5'd3, 5'd1, 5'd2, 32'h0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0), C_NOSRA);
        snap      = obs;
        in_valid  = 1'b1;
        in_instr  = 32'h402081B3;
        in_pc     = 32'h204;
        out_ready = 1'b0;
        pend.e    = ev(32'h204, 5'd3, 5'd1, 5'd2, 32'h0, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
        pend.c    = C_NOSRA;
        for (int i = 0; i < 3; i++) begin
            tick("bp_stall");
            chk("bp_stable", obs, snap, {95{1'b1}});
        end
        out_ready = 1'b1;
        tick("bp_release");
        idle("bp_drain");

        // Flush while stalled with a simultaneous offer drops both
        send("fl_first", 32'h00335293, 32'h300,
             ev(32'h300, 5'd5, 5'd6, 5'd3, 32'h3, 3'b101, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 3'b000, 3'b101, 1'b0), C_ALL);
        in_valid  = 1'b1;
        in_instr  = 32'h402081B3;
        in_pc     = 32'h304;
        flush     = 1'b1;
        out_ready = 1'b0;
        tick("flush");
        idle("flush_after");

        // Flush with an empty stage and an offer also drops the offer
        in_valid  = 1'b1;
        in_instr  = 32'h002081B3;
        flush     = 1'b1;
        out_ready = 1'b1;
        tick("flush_empty");
        idle("flush_empty_after");

        // Asynchronous reset during a stall
        send("rs_first", 32'h002081B3, 32'h400,
             ev(32'h400, 5'd3, 5'd1, 5'd2, 32'h0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0), C_NOSRA);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick("rs_stall");
        rst_n = 1'b0;
        #2;
        chk1("async_reset/out_valid", out_valid, 1'b0);
        chk("async_reset/outputs", obs, 95'd0, mk_mask(C_ALL));
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
